// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: state encoding,
// parity modes, standard divisors and a parity helper.
package uart_pkg;

    typedef logic [2:0] uart_state_t;

    localparam uart_state_t IDLE   = 3'd0;
    localparam uart_state_t FETCH  = 3'd1;
    localparam uart_state_t START  = 3'd2;
    localparam uart_state_t DATA   = 3'd3;
    localparam uart_state_t PARITY = 3'd4;
    localparam uart_state_t STOP   = 3'd5;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    localparam int DIV_9600_50M = 5208;
    localparam int DIV_SIM      = 56;

    // Upper bits of d are zero-filled by the caller, so ^d covers only payload.
    function automatic logic par_bit(input logic [8:0] d, input int mode);
        return (mode == PAR_ODD) ? ~(^d) : (^d);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLK_DIV-1 while enabled, ticks on the last count.
// Shared between the transmitter and the planned receiver.
module uart_baud_gen import uart_pkg::*; #(
    parameter int CLK_DIV = DIV_9600_50M
) (
    input  logic sclk,
    input  logic s_rst_n,
    input  logic clear,
    input  logic enable,
    output logic bit_tick
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    if (CLK_DIV < 2) begin : g_bad_div
        $error("uart_baud_gen: CLK_DIV must be >= 2");
    end

    logic [CNT_W-1:0] cnt;

    assign bit_tick = enable && (cnt == LAST);

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= bit_tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter that pulls one word per frame from the read-back FIFO
// and serialises it LSB first with optional parity and 1..2 stop bits.
module uart_tx_frame import uart_pkg::*; #(
    parameter int CLK_DIV     = DIV_9600_50M,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = PAR_NONE,
    parameter int STOP_BITS   = 1
) (
    input  logic                 sclk,
    input  logic                 s_rst_n,
    input  logic                 rfifo_empty,
    output logic                 rfifo_rd_en,
    input  logic [DATA_BITS-1:0] rfifo_rd_data,
    output logic                 rs232_tx,
    output logic                 tx_busy,
    output logic                 frame_done
);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
        $error("uart_tx_frame: DATA_BITS must be 5..9");
    end
    if (PARITY_MODE < PAR_NONE || PARITY_MODE > PAR_EVEN) begin : g_bad_par
        $error("uart_tx_frame: PARITY_MODE must be 0..2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_frame: STOP_BITS must be 1..2");
    end

    localparam logic [3:0] LAST_IDX  = 4'(DATA_BITS - 1);
    localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

    uart_state_t          state;
    logic [DATA_BITS-1:0] shreg;
    logic                 par;
    logic [3:0]           bit_idx;
    logic                 stop_idx;
    logic                 bit_tick;
    logic                 baud_clr;
    logic                 baud_en;

    // Counter is held clear during FETCH so START begins a fresh bit period.
    assign baud_clr = (state == FETCH);
    assign baud_en  = (state == START) || (state == DATA) ||
                      (state == PARITY) || (state == STOP);

    uart_baud_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_baud (
        .sclk     (sclk),
        .s_rst_n  (s_rst_n),
        .clear    (baud_clr),
        .enable   (baud_en),
        .bit_tick (bit_tick)
    );

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state       <= IDLE;
            rs232_tx    <= 1'b1;
            rfifo_rd_en <= 1'b0;
            tx_busy     <= 1'b0;
            frame_done  <= 1'b0;
            shreg       <= '0;
            par         <= 1'b0;
            bit_idx     <= '0;
            stop_idx    <= 1'b0;
        end else begin
            rfifo_rd_en <= 1'b0;
            frame_done  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!rfifo_empty) begin
                        rfifo_rd_en <= 1'b1;
                        tx_busy     <= 1'b1;
                        state       <= FETCH;
                    end
                end
                FETCH: begin
                    shreg    <= rfifo_rd_data;
                    par      <= par_bit(9'(rfifo_rd_data), PARITY_MODE);
                    rs232_tx <= 1'b0;
                    state    <= START;
                end
                START: begin
                    if (bit_tick) begin
                        rs232_tx <= shreg[0];
                        shreg    <= shreg >> 1;
                        bit_idx  <= '0;
                        state    <= DATA;
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        if (bit_idx == LAST_IDX) begin
                            if (PARITY_MODE != PAR_NONE) begin
                                rs232_tx <= par;
                                state    <= PARITY;
                            end else begin
                                rs232_tx <= 1'b1;
                                stop_idx <= 1'b0;
                                state    <= STOP;
                            end
                        end else begin
                            rs232_tx <= shreg[0];
                            shreg    <= shreg >> 1;
                            bit_idx  <= bit_idx + 4'd1;
                        end
                    end
                end
                PARITY: begin
                    if (bit_tick) begin
                        rs232_tx <= 1'b1;
                        stop_idx <= 1'b0;
                        state    <= STOP;
                    end
                end
                STOP: begin
                    if (bit_tick) begin
                        if (stop_idx == LAST_STOP) begin
                            frame_done <= 1'b1;
                            tx_busy    <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end
                end
                default: begin
                    rs232_tx <= 1'b1;
                    tx_busy  <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
